enigma_stepper: RTL and testbench

Rotor stepping controller that sits directly upstream of the rotor substitution stage. It turns the raw, bouncing active-low letter pushbutton into exactly one advance per press. It then advances three rotor positions (left, middle, right; each 0–25 = A–Z) with historically correct notch carry and middle-rotor double-stepping. The resulting positions and a one-cycle step strobe drive the rotor stage and the HEX/LED debug displays.

---
 rtl/enigma_pkg.sv | 33 +++
 rtl/enigma_stepper_key_debouncer.sv | 68 ++++++
 rtl/enigma_stepper.sv | 110 +++++++++++
 tb/tb_enigma_stepper.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared constants, state encoding and letter arithmetic for the Enigma rotor stepper.
// Letter positions are mod-26 values held in 5 bits.
package enigma_pkg;

  localparam int ALPHABET = 26;
  localparam int LETTER_W = 5;

  localparam int NOTCH_R_DEFAULT = 21;  // V
  localparam int NOTCH_M_DEFAULT = 4;   // E

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_STEP = 4'd1,
    ST_HELD = 4'd2
  } stepper_state_e;

  // Advance one letter, wrapping Z back to A.
  function automatic logic [LETTER_W-1:0] letter_inc(input logic [LETTER_W-1:0] v);
    if (v == LETTER_W'(ALPHABET - 1)) begin
      return '0;
    end
    return v + LETTER_W'(1);
  endfunction

  // Out-of-range switch settings load as A.
  function automatic logic [LETTER_W-1:0] letter_clamp(input logic [LETTER_W-1:0] v);
    if (v >= LETTER_W'(ALPHABET)) begin
      return '0;
    end
    return v;
  endfunction

endpackage

// File: rtl/enigma_stepper_key_debouncer.sv
// Two-flop synchronizer plus stability counter for the active-low letter key.
// Output pressed is the debounced, active-high key level.
module key_debouncer
  import enigma_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             pressed_q, pressed_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       prime_q, prime_d;
  logic             armed_q, armed_d;
  logic             differs;

  // After reset the synchronizer holds its released reset value for two
  // cycles; only arm once a genuine released level has been observed so a
  // key held through reset cannot qualify as a fresh press.
  always_comb begin
    prime_d = prime_q;
    if (prime_q != 2'd2) begin
      prime_d = prime_q + 2'd1;
    end
    armed_d = armed_q | ((prime_q == 2'd2) & sync2_q);
  end

  assign differs = armed_q & ((~sync2_q) != pressed_q);

  always_comb begin
    pressed_d = pressed_q;
    count_d   = '0;
    if (differs) begin
      if (count_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        pressed_d = ~pressed_q;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      pressed_q <= 1'b0;
      count_q   <= '0;
      prime_q   <= 2'd0;
      armed_q   <= 1'b0;
    end else begin
      sync1_q   <= key_n;
      sync2_q   <= sync1_q;
      pressed_q <= pressed_d;
      count_q   <= count_d;
      prime_q   <= prime_d;
      armed_q   <= armed_d;
    end
  end

  assign pressed = pressed_q;

endmodule

// File: rtl/enigma_stepper.sv
// Three-rotor stepping controller: one advance per debounced key press, with
// notch carry and middle-rotor double stepping.
module enigma_stepper
  import enigma_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned NOTCH_R         = NOTCH_R_DEFAULT,
  parameter int unsigned NOTCH_M         = NOTCH_M_DEFAULT
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                key_n,
  input  logic                load,
  input  logic [LETTER_W-1:0] init_l,
  input  logic [LETTER_W-1:0] init_m,
  input  logic [LETTER_W-1:0] init_r,
  output logic [LETTER_W-1:0] pos_l,
  output logic [LETTER_W-1:0] pos_m,
  output logic [LETTER_W-1:0] pos_r,
  output logic                step,
  output logic [3:0]          state
);

  localparam logic [LETTER_W-1:0] NOTCH_R_L = LETTER_W'(NOTCH_R);
  localparam logic [LETTER_W-1:0] NOTCH_M_L = LETTER_W'(NOTCH_M);

  stepper_state_e      state_q, state_d;
  logic [LETTER_W-1:0] pos_l_q, pos_l_d;
  logic [LETTER_W-1:0] pos_m_q, pos_m_d;
  logic [LETTER_W-1:0] pos_r_q, pos_r_d;
  logic                step_q, step_d;
  logic                pressed;
  logic                advance;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (CLOCK_50),
    .rst_n  (resetn),
    .key_n  (key_n),
    .pressed(pressed)
  );

  // Rotors advance on the IDLE->STEP transition so step and the new
  // positions are both visible during the STEP cycle.
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pressed) begin
          state_d = ST_STEP;
          advance = 1'b1;
        end
      end
      ST_STEP: state_d = ST_HELD;
      ST_HELD: begin
        if (!pressed) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pos_l_d = pos_l_q;
    pos_m_d = pos_m_q;
    pos_r_d = pos_r_q;
    step_d  = 1'b0;
    if (load) begin
      pos_l_d = letter_clamp(init_l);
      pos_m_d = letter_clamp(init_m);
      pos_r_d = letter_clamp(init_r);
    end else if (advance) begin
      step_d  = 1'b1;
      pos_r_d = letter_inc(pos_r_q);
      // Middle notch moves the middle rotor too: the double step.
      if ((pos_r_q == NOTCH_R_L) || (pos_m_q == NOTCH_M_L)) begin
        pos_m_d = letter_inc(pos_m_q);
      end
      if (pos_m_q == NOTCH_M_L) begin
        pos_l_d = letter_inc(pos_l_q);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      pos_l_q <= '0;
      pos_m_q <= '0;
      pos_r_q <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_l_q <= pos_l_d;
      pos_m_q <= pos_m_d;
      pos_r_q <= pos_r_d;
      step_q  <= step_d;
    end
  end

  assign pos_l = pos_l_q;
  assign pos_m = pos_m_q;
  assign pos_r = pos_r_q;
  assign step  = step_q;
  assign state = state_q;

endmodule

// File: tb/tb_enigma_stepper.sv
// Directed bench for enigma_stepper with a 4-cycle debounce window.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_enigma_stepper;

  logic       clk;
  logic       resetn;
  logic       key_n;
  logic       load;
  logic [4:0] init_l, init_m, init_r;
  logic [4:0] pos_l, pos_m, pos_r;
  logic       step;
  logic [3:0] state;

  int tests_run = 0;
  int tests_failed = 0;
  int step_cnt = 0;
  int s0;

  enigma_stepper #(
    .DEBOUNCE_CYCLES(4),
    .NOTCH_R        (21),
    .NOTCH_M        (4)
  ) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
    .key_n   (key_n),
    .load    (load),
    .init_l  (init_l),
    .init_m  (init_m),
    .init_r  (init_r),
    .pos_l   (pos_l),
    .pos_m   (pos_m),
    .pos_r   (pos_r),
    .step    (step),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (step === 1'b1) step_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_pos(input string tag, input int l, input int m, input int r);
    check({tag, "_l"}, 32'(pos_l), 32'(l));
    check({tag, "_m"}, 32'(pos_m), 32'(m));
    check({tag, "_r"}, 32'(pos_r), 32'(r));
  endtask

  task automatic press(input int n);
    key_n = 1'b0;
    cycles(n);
    key_n = 1'b1;
    cycles(12);
  endtask

  task automatic do_load(input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
    init_l = l; init_m = m; init_r = r;
    load = 1'b1;
    cycles(1);
    load = 1'b0;
    cycles(1);
  endtask

  initial begin
    resetn = 1'b0; key_n = 1'b1; load = 1'b0;
    init_l = '0; init_m = '0; init_r = '0;
    cycles(3);
    check("reset_step", 32'(step), 32'd0);
    check("reset_state", 32'(state), 32'd0);
    check_pos("reset_pos", 0, 0, 0);
    resetn = 1'b1;
    cycles(5);

    // Clean press: AAA -> AAB
    s0 = step_cnt;
    press(10);
    check("clean_steps", 32'(step_cnt - s0), 32'd1);
    check_pos("clean_pos", 0, 0, 1);
    check("clean_idle", 32'(state), 32'd0);

    // Double step: ADU -> ADV -> AEW -> BFX
    do_load(5'd0, 5'd3, 5'd20);
    check_pos("load_adu", 0, 3, 20);
    press(10);
    check_pos("ds1", 0, 3, 21);
    press(10);
    check_pos("ds2", 0, 4, 22);
    press(10);
    check_pos("ds3", 1, 5, 23);
    $display("[TB] double-step sequence done pos=%0d,%0d,%0d", pos_l, pos_m, pos_r);

    // Right and left wraps
    do_load(5'd0, 5'd0, 5'd25);
    press(10);
    check_pos("wrap_r", 0, 0, 0);
    do_load(5'd25, 5'd4, 5'd0);
    press(10);
    check_pos("wrap_l", 0, 5, 1);

    // Bouncing press then steady hold: one step
    s0 = step_cnt;
    for (int i = 0; i < 10; i++) begin
      key_n = i[0];
      cycles(2);
    end
    key_n = 1'b0;
    cycles(50);
    key_n = 1'b1;
    cycles(12);
    check("bounce_steps", 32'(step_cnt - s0), 32'd1);
    check_pos("bounce_pos", 0, 5, 2);

    // Short glitch: no step
    s0 = step_cnt;
    key_n = 1'b0;
    cycles(3);
    key_n = 1'b1;
    cycles(12);
    check("glitch_steps", 32'(step_cnt - s0), 32'd0);
    check_pos("glitch_pos", 0, 5, 2);

    // Out-of-range init clamps to 0; press during load is consumed
    init_l = 5'd2; init_m = 5'd7; init_r = 5'd30;
    load = 1'b1;
    cycles(2);
    check_pos("clamp_pos", 2, 7, 0);
    s0 = step_cnt;
    key_n = 1'b0;
    cycles(10);
    check("loadpress_state", 32'(state), 32'd2);
    check("loadpress_steps", 32'(step_cnt - s0), 32'd0);
    check_pos("loadpress_pos", 2, 7, 0);
    key_n = 1'b1;
    cycles(12);
    load = 1'b0;
    cycles(1);
    check("loadpress_idle", 32'(state), 32'd0);

    // Reset in HELD with key held, then release and press again
    s0 = step_cnt;
    key_n = 1'b0;
    cycles(10);
    check("held_state", 32'(state), 32'd2);
    check("held_steps", 32'(step_cnt - s0), 32'd1);
    resetn = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    check_pos("rst_pos", 0, 0, 0);
    cycles(2);
    resetn = 1'b1;
    s0 = step_cnt;
    cycles(20);
    check("post_rst_steps", 32'(step_cnt - s0), 32'd0);
    check("post_rst_state", 32'(state), 32'd0);
    key_n = 1'b1;
    cycles(12);
    press(10);
    check("repress_steps", 32'(step_cnt - s0), 32'd1);
    check_pos("repress_pos", 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
